// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns, FSM state type and digit width shared by the
// seg7 encoder/monitor slice. Segment bit 0 = a ... bit 6 = g, active-high.
package seg7_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_TRACK = 2'd2
  } mon_state_e;

  function automatic logic [DIGIT_W-1:0] next_digit(
    input logic [DIGIT_W-1:0] d
  );
    return (d == 4'd9) ? '0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational 7-segment pattern to BCD digit.
// Exact inverse of the seg7 encoder; anything else reports invalid.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0]         seg_i,
  output logic               valid_o,
  output logic [DIGIT_W-1:0] digit_o
);

  always_comb begin
    valid_o = 1'b1;
    digit_o = '0;
    unique case (seg_i)
      SEG_0:   digit_o = 4'd0;
      SEG_1:   digit_o = 4'd1;
      SEG_2:   digit_o = 4'd2;
      SEG_3:   digit_o = 4'd3;
      SEG_4:   digit_o = 4'd4;
      SEG_5:   digit_o = 4'd5;
      SEG_6:   digit_o = 4'd6;
      SEG_7:   digit_o = 4'd7;
      SEG_8:   digit_o = 4'd8;
      SEG_9:   digit_o = 4'd9;
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_monitor.sv
// seg7_monitor: glitch-filtered 7-segment receiver with sequence/period check.
// Define SEG7_MON_SYNC_EN to add a 2-flop synchronizer ahead of the filter.
module seg7_monitor
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int PERIOD_W      = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          seg_in,
  input  logic                clr_err,
  output logic [DIGIT_W-1:0]  digit,
  output logic                digit_valid,
  output logic [PERIOD_W-1:0] period,
  output logic                period_stb,
  output logic [7:0]          recovered_cmp,
  output logic                seq_err,
  output logic                inv_err,
  output logic                ovf
);

  localparam logic [7:0] STAB_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;
  localparam logic [PERIOD_W-1:0] CMP_MAX = PERIOD_W'(255);

  logic [6:0] sample;

`ifdef SEG7_MON_SYNC_EN
  logic [6:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= seg_in;
      sync2_q <= sync1_q;
    end
  end

  assign sample = sync2_q;
`else
  assign sample = seg_in;
`endif

  logic [6:0]          cand_q, last_q, last_d;
  logic [7:0]          stab_q, stab_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d, cnt_inc, shr;
  logic                accept;
  logic                dec_valid, in_seq;
  logic [DIGIT_W-1:0]  dec_digit;
  mon_state_e          state_q, state_d;

  logic [DIGIT_W-1:0]  digit_q, digit_d;
  logic                dv_q, dv_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                stb_q;
  logic [7:0]          rc_q, rc_d, rc_new;
  logic                seq_q, seq_d, inv_q, inv_d, ovf_q, ovf_d;
  logic                load_digit, load_period, set_seq, set_inv;

  seg7_decode u_dec (
    .seg_i   (cand_q),
    .valid_o (dec_valid),
    .digit_o (dec_digit)
  );

  // A pattern already accepted never re-accepts, so glitches back to it are silent.
  assign accept = (sample == cand_q) && (stab_q == STAB_LAST)
               && (cand_q != last_q);
  assign in_seq = (dec_digit == next_digit(digit_q));

  always_comb begin
    stab_d = stab_q;
    if (sample != cand_q)
      stab_d = '0;
    else if (stab_q != STAB_LAST)
      stab_d = stab_q + 8'd1;
  end

  assign last_d  = accept ? cand_q : last_q;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + PERIOD_W'(1);
  assign cnt_d   = accept ? '0 : cnt_inc;
  assign shr     = cnt_inc >> 10;
  assign rc_new  = (shr > CMP_MAX) ? 8'hFF : shr[7:0];

  always_comb begin
    state_d = state_q;
    if (accept) begin
      unique case (state_q)
        ST_IDLE:
          if (dec_valid) state_d = ST_FIRST;
        ST_FIRST:
          if (!dec_valid)  state_d = ST_IDLE;
          else if (in_seq) state_d = ST_TRACK;
        ST_TRACK:
          if (!dec_valid)   state_d = ST_IDLE;
          else if (!in_seq) state_d = ST_FIRST;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    load_digit  = 1'b0;
    load_period = 1'b0;
    set_seq     = 1'b0;
    set_inv     = 1'b0;
    if (accept) begin
      if (!dec_valid) begin
        set_inv = 1'b1;
      end else begin
        load_digit  = 1'b1;
        set_seq     = (state_q != ST_IDLE) && !in_seq;
        load_period = (state_q == ST_TRACK) && in_seq;
      end
    end
  end

  assign digit_d  = load_digit ? dec_digit : digit_q;
  assign dv_d     = accept ? dec_valid : dv_q;
  assign period_d = load_period ? cnt_inc : period_q;
  assign rc_d     = load_period ? rc_new : rc_q;
  assign seq_d    = set_seq | (seq_q & ~clr_err);
  assign inv_d    = set_inv | (inv_q & ~clr_err);
  assign ovf_d    = (cnt_q == CNT_MAX) | (ovf_q & ~clr_err);

  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q   <= '0;
      last_q   <= '0;
      stab_q   <= '0;
      cnt_q    <= '0;
      state_q  <= ST_IDLE;
      digit_q  <= '0;
      dv_q     <= 1'b0;
      period_q <= '0;
      stb_q    <= 1'b0;
      rc_q     <= '0;
      seq_q    <= 1'b0;
      inv_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      cand_q   <= sample;
      last_q   <= last_d;
      stab_q   <= stab_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      digit_q  <= digit_d;
      dv_q     <= dv_d;
      period_q <= period_d;
      stb_q    <= load_period;
      rc_q     <= rc_d;
      seq_q    <= seq_d;
      inv_q    <= inv_d;
      ovf_q    <= ovf_d;
    end
  end

  assign digit         = digit_q;
  assign digit_valid   = dv_q;
  assign period        = period_q;
  assign period_stb    = stb_q;
  assign recovered_cmp = rc_q;
  assign seq_err       = seq_q;
  assign inv_err       = inv_q;
  assign ovf           = ovf_q;

endmodule

// File: doc/seg7_monitor.md
# seg7_monitor

Receive-side companion to the seg7 digit counter. It samples a 7-segment pattern from pins driven by another design or by a loopback, and filters out glitches. It decodes the pattern back to a BCD digit, checks that digits advance 0→9→0, and measures the cycles between accepted digit changes. It also recovers the 8-bit compare setting that produced that period. It sits between the pins and the status and readout logic.

## Interface
- `STABLE_CYCLES`, default 4: number of consecutive identical samples required before a pattern is accepted; legal range 1..255.
- `PERIOD_W`, default 24: width of the period counter.
- `clk` in, 1: clock.
- `reset` in, 1: synchronous, active-high.
- `seg_in` in, 7: segment pattern; bit 0 = a … bit 6 = g; active-high; may be asynchronous.
- `clr_err` in, 1: single-cycle pulse that clears the sticky error flags.
- `digit` out, 4: last accepted digit, 0..9.
- `digit_valid` out, 1: `digit` holds a decoded value.
- `period` out, PERIOD_W: last measured period in clk cycles.
- `period_stb` out, 1: one-cycle pulse when `period` updates.
- `recovered_cmp` out, 8: `period >> 10`, saturated to 255.
- `seq_err` out, 1: sticky; an accepted digit was not the previous digit + 1 (mod 10).
- `inv_err` out, 1: sticky; a stable pattern decoded to none of the ten digits.
- `ovf` out, 1: sticky; the period counter saturated.

## Operation
- **Decode.** Uses the same encoding as the seg7 encoder:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66
  - 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F
  - Any other pattern is invalid.
- **Filter.**
  - The sampled pattern is compared with a candidate register.
  - On mismatch, the candidate is loaded and the stability count is cleared.
  - An accept event occurs when the candidate has matched for STABLE_CYCLES consecutive samples and differs from the last accepted pattern.
  - Each stable pattern produces exactly one accept event.
- **Cycle counter.**
  - Increments every cycle and saturates at all-ones; saturation sets `ovf`.
  - Cleared on every accept event.
- **FSM states.**
  - IDLE:
    - A valid accept goes to FIRST and sets `digit_valid`.
    - An invalid accept sets `inv_err` and stays in IDLE.
  - FIRST (partial period, which is discarded):
    - Valid and in sequence → TRACK.
    - Valid but out of sequence → sets `seq_err`, stays in FIRST.
    - Invalid → IDLE.
  - TRACK:
    - Valid and in sequence → loads `period` from the count, pulses `period_stb`, stays in TRACK.
    - Valid but out of sequence → sets `seq_err`, goes to FIRST, no strobe.
    - Invalid → IDLE.
- **Any invalid accept** sets `inv_err`, clears `digit_valid` and leaves `digit` unchanged.
- **Wrap-around.** The 9→0 transition is in sequence.
- **Error clearing.** `clr_err` clears `seq_err`, `inv_err` and `ovf`. If an error set and `clr_err` occur in the same cycle, the set wins.
- **recovered_cmp.** Computed from `period` as `period[PERIOD_W-1:10]`; any nonzero bit above bit 17 forces 255. An encoder with compare value C produces period = 1024·C + 1, so `recovered_cmp` = C.

## Timing
- Reset values:
  - `digit` = 0, `digit_valid` = 0, `period` = 0, `period_stb` = 0, `recovered_cmp` = 0, all sticky flags = 0.
  - FSM in IDLE; candidate, last-accepted and synchronizer registers = 0x00.
- Latency from a `seg_in` change settling before edge N to outputs updating:
  - with the synchronizer: edge N+2+STABLE_CYCLES;
  - without it: edge N+STABLE_CYCLES.
- `period_stb` is high exactly in the cycle following the edge at which `period` updates.
- `recovered_cmp` updates in the same cycle as `period`.
- Measured period equals the true spacing between pin changes, because the filter delay cancels.
- Reset asserted mid-measurement returns every register to its reset value on the next edge. No strobe is issued.

## Configuration
- `SEG7_MON_SYNC_EN`:
  - Defined: `seg_in` passes through a 2-flop synchronizer before the filter.
  - Undefined: `seg_in` feeds the filter directly, for synchronous loopback; latency drops by 2 cycles.
  - All other behaviour is identical.

## Structure
- Shared package `seg7_pkg` holds:
  - the ten segment-pattern constants;
  - the FSM state typedef (IDLE, FIRST, TRACK);
  - the digit width constant.
- One sub-module, `seg7_decode`: combinational pattern → {valid, digit}. It is the exact inverse of the seg7 encoder.

## Test plan
- Drive 0x3F, 0x06, 0x5B, each held 4000 cycles, STABLE_CYCLES=4 → `digit` goes 0,1,2; one `period_stb` with `period`=4000.
- Loopback from the counter with compare 5 (period 5121) through 0→9→0 → `recovered_cmp`=5, `seq_err`=0 across the wrap.
- Glitch 0x4F for 3 cycles inside a stable 0x06 → no accept, `digit` stays 1.
- Jump 2→5 → `seq_err`=1, no strobe at the jump; the next in-sequence change also produces no strobe (FIRST state).
- Stable 0x00 → `inv_err`=1, `digit_valid`=0; `clr_err` pulse → flag clears.
- Hold one pattern for more than 2^24 cycles → `ovf`=1 and `period`=0xFFFFFF at the next change. Assert reset mid-hold → all outputs at their reset values.
